// File: rtl/time_clock_ctrl_pkg.sv
// Shared definitions for the stopwatch controller and the display decoder.
package time_clock_ctrl_pkg;

  localparam int unsigned CNT_W_DEF     = 14;
  localparam int unsigned MAX_COUNT_DEF = 9999;
  localparam int unsigned LED_W         = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  // One-cycle button events after edge detection.
  typedef struct packed {
    logic clear;
    logic start;
    logic lap;
  } btn_evt_t;

  // One-hot status nibble {PAUSE,LAP,RUN,IDLE}.
  function automatic logic [3:0] state_onehot(input state_e s);
    logic [3:0] oh;
    oh = 4'b0000;
    case (s)
      S_IDLE:  oh = 4'b0001;
      S_RUN:   oh = 4'b0010;
      S_LAP:   oh = 4'b0100;
      S_PAUSE: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // States in which the time base advances.
  function automatic logic is_counting(input state_e s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/time_clock_ctrl_btn_edge.sv
// Per-button history register and rising-edge pulse.
module tc_btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_c_o
);

  logic hist_q;
  logic arm_q;

  // Track previous level; arm_q stays low for the first edge after reset so a
  // button held through reset release is absorbed into history, not an event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      hist_q <= btn_i;
      arm_q  <= 1'b1;
    end
  end

  assign rise_c_o = btn_i & ~hist_q & arm_q;

endmodule

// File: rtl/time_clock_ctrl.sv
// Stopwatch run control: start/pause, lap freeze, clear, tenth-second count.
module time_clock_ctrl
  import time_clock_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic             sysclk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_btn_start,
  input  logic             i_btn_lap,
  input  logic             i_btn_clear,
  output logic [CNT_W-1:0] o_timeData,
  output logic [LED_W-1:0] o_tcLED,
  output logic             o_running,
  output logic             o_wrap
);

  btn_evt_t evt_c;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lap_q,   lap_d;
  logic             blink_q, blink_d;
  logic             wrap_q,  wrap_d;

  logic [CNT_W-1:0] time_q,  time_d;
  logic [LED_W-1:0] led_q,   led_d;
  logic             run_q,   run_d;
  logic             owrap_q, owrap_d;

  tc_btn_edge u_edge_start (
    .clk_i    (sysclk),
    .rst_i    (i_rst),
    .btn_i    (i_btn_start),
    .rise_c_o (evt_c.start)
  );

  tc_btn_edge u_edge_lap (
    .clk_i    (sysclk),
    .rst_i    (i_rst),
    .btn_i    (i_btn_lap),
    .rise_c_o (evt_c.lap)
  );

  tc_btn_edge u_edge_clear (
    .clk_i    (sysclk),
    .rst_i    (i_rst),
    .btn_i    (i_btn_clear),
    .rise_c_o (evt_c.clear)
  );

  // FSM, count, lap snapshot and wrap/blink state registers.
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lap_q   <= '0;
      blink_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      blink_q <= blink_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state: clear overrides everything; start beats lap; ticks count in RUN/LAP.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    blink_d = blink_q;
    wrap_d  = 1'b0;

    if (evt_c.clear) begin
      state_d = S_IDLE;
      count_d = '0;
      lap_d   = '0;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (evt_c.start) state_d = S_RUN;
        end
        S_RUN: begin
          if (evt_c.start) begin
            state_d = S_PAUSE;
          end else if (evt_c.lap) begin
            state_d = S_LAP;
            lap_d   = count_q;
          end
        end
        S_LAP: begin
          if (evt_c.start)    state_d = S_PAUSE;
          else if (evt_c.lap) state_d = S_RUN;
        end
        S_PAUSE: begin
          if (evt_c.start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase

      if (i_tick && is_counting(state_q)) begin
        blink_d = ~blink_q;
        if (count_q == CNT_W'(MAX_COUNT)) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  // Display/LED values derived from the current registered state.
  always_comb begin
    time_d  = count_q;
    led_d   = '0;
    run_d   = 1'b0;
    owrap_d = wrap_q;

    if (state_q == S_LAP) time_d = lap_q;
    led_d = {blink_q, 3'b000, state_onehot(state_q)};
    run_d = is_counting(state_q);
  end

  // Output registers, one cycle behind the internal state.
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      time_q  <= '0;
      led_q   <= '0;
      run_q   <= 1'b0;
      owrap_q <= 1'b0;
    end else begin
      time_q  <= time_d;
      led_q   <= led_d;
      run_q   <= run_d;
      owrap_q <= owrap_d;
    end
  end

  assign o_timeData = time_q;
  assign o_tcLED    = led_q;
  assign o_running  = run_q;
  assign o_wrap     = owrap_q;

endmodule

// File: tb/tb_time_clock_ctrl.sv
// Scoreboard bench for time_clock_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_time_clock_ctrl;

  logic        sysclk = 1'b0;
  logic        i_rst;
  logic        i_tick;
  logic        i_btn_start;
  logic        i_btn_lap;
  logic        i_btn_clear;
  logic [13:0] o_timeData;
  logic [7:0]  o_tcLED;
  logic        o_running;
  logic        o_wrap;

  typedef struct {
    int          tag;
    string       name;
    logic [13:0] t;
    logic [7:0]  led;
    logic        run;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  time_clock_ctrl dut (
    .sysclk      (sysclk),
    .i_rst       (i_rst),
    .i_tick      (i_tick),
    .i_btn_start (i_btn_start),
    .i_btn_lap   (i_btn_lap),
    .i_btn_clear (i_btn_clear),
    .o_timeData  (o_timeData),
    .o_tcLED     (o_tcLED),
    .o_running   (o_running),
    .o_wrap      (o_wrap)
  );

  initial forever #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle tag has come due.
  always @(negedge sysclk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.tag != cyc || o_timeData !== e.t || o_tcLED !== e.led ||
          o_running !== e.run || o_wrap !== e.wrap) begin
        errors++;
        $display("FAIL %s cyc=%0d: time act %0d exp %0d, led act %b exp %b, run act %b exp %b, wrap act %b exp %b",
                 e.name, cyc, o_timeData, e.t, o_tcLED, e.led, o_running, e.run, o_wrap, e.wrap);
      end
    end
  end

  task automatic step(input logic t, input logic s, input logic l, input logic c);
    i_tick      = t;
    i_btn_start = s;
    i_btn_lap   = l;
    i_btn_clear = c;
    @(posedge sysclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_start();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_lap();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_clear();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_at(input int tag, input string nm, input logic [13:0] t,
                           input logic [7:0] led, input logic run, input logic wrap);
    exp_t x;
    x.tag  = tag;
    x.name = nm;
    x.t    = t;
    x.led  = led;
    x.run  = run;
    x.wrap = wrap;
    sb.push_back(x);
  endtask

  // Outputs already registered at the last edge.
  task automatic expect_now(input string nm, input logic [13:0] t, input logic [7:0] led,
                            input logic run, input logic wrap);
    expect_at(cyc, nm, t, led, run, wrap);
  endtask

  // Outputs after the next edge (one-cycle output latency).
  task automatic expect_next(input string nm, input logic [13:0] t, input logic [7:0] led,
                             input logic run, input logic wrap);
    expect_at(cyc + 1, nm, t, led, run, wrap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("reset", 14'd0, 8'h00, 1'b0, 1'b0);
    i_rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("idle", 14'd0, 8'h01, 1'b0, 1'b0);

    // Run and lap freeze
    press_start();
    tick_n(25);
    expect_next("run25", 14'd25, 8'h82, 1'b1, 1'b0);
    tick_n(15);
    expect_next("run40", 14'd40, 8'h02, 1'b1, 1'b0);
    press_lap();
    expect_next("lap_freeze", 14'd40, 8'h04, 1'b1, 1'b0);
    tick_n(10);
    expect_next("lap_hold", 14'd40, 8'h04, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_next("lap_live", 14'd50, 8'h02, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear, lap ignored in IDLE
    press_clear();
    expect_next("clear", 14'd0, 8'h01, 1'b0, 1'b0);
    press_lap();
    expect_next("idle_lap", 14'd0, 8'h01, 1'b0, 1'b0);

    // Pause / resume, start+tick coincidences
    press_start();
    tick_n(12);
    expect_next("run12", 14'd12, 8'h02, 1'b1, 1'b0);
    press_start();
    expect_next("pause12", 14'd12, 8'h08, 1'b0, 1'b0);
    tick_n(5);
    expect_next("pause_hold", 14'd12, 8'h08, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("resume_tick", 14'd12, 8'h02, 1'b1, 1'b0);
    tick_n(1);
    expect_next("run13", 14'd13, 8'h82, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("pause_tick", 14'd14, 8'h08, 1'b0, 1'b0);

    // LAP -> start -> PAUSE shows live count; lap ignored in PAUSE; start beats lap
    press_start();
    tick_n(1);
    expect_next("run15", 14'd15, 8'h82, 1'b1, 1'b0);
    press_lap();
    expect_next("lap15", 14'd15, 8'h84, 1'b1, 1'b0);
    tick_n(1);
    expect_next("lap15_hold", 14'd15, 8'h04, 1'b1, 1'b0);
    press_start();
    expect_next("lap_pause", 14'd16, 8'h08, 1'b0, 1'b0);
    press_lap();
    expect_next("pause_lap", 14'd16, 8'h08, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("start_over_lap", 14'd16, 8'h02, 1'b1, 1'b0);

    // Wrap at MAX_COUNT
    press_clear();
    press_start();
    tick_n(9999);
    expect_next("pre_wrap", 14'd9999, 8'h82, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("wrap", 14'd0, 8'h02, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("wrap_once", 14'd0, 8'h02, 1'b1, 1'b0);
    tick_n(1);
    expect_next("post_wrap", 14'd1, 8'h82, 1'b1, 1'b0);

    // Clear + start + tick together while RUN at 7
    press_clear();
    press_start();
    tick_n(7);
    expect_next("run7", 14'd7, 8'h82, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("clear_prio", 14'd0, 8'h01, 1'b0, 1'b0);

    // Held start gives one event
    repeat (50) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_next("hold_mid", 14'd0, 8'h02, 1'b1, 1'b0);
    repeat (50) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_next("hold_end", 14'd0, 8'h02, 1'b1, 1'b0);

    // Reset mid-run with start still held
    repeat (33) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    expect_next("pre_rst", 14'd33, 8'h82, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_now("rst_mid", 14'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_next("rst_held", 14'd0, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    press_start();
    tick_n(2);
    expect_next("after_rst", 14'd2, 8'h02, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending act %0d exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
